// File: rtl/rr_mux_pkg.sv
// Shared helpers for the round-robin mux arbiter.
package rr_mux_pkg;

  // Index width large enough for the widest legal channel count (16).
  localparam int unsigned IDX_W = 4;
  typedef logic [IDX_W-1:0] idx_t;

  // Modulo-n increment; explicit wrap because n need not be a power of 2.
  function automatic idx_t next_idx(idx_t idx, int unsigned n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational circular first-one search starting at ptr.
module rr_grant #(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant_idx,
  output logic          grant_any
);

  logic [2*N-1:0] req_rot;
  logic [SW-1:0]  off;
  logic [SW:0]    sum;

  // Rotate so bit 0 is the channel at ptr; the duplicated copy handles wrap.
  assign req_rot = {req, req} >> ptr;

  always_comb begin
    off = '0;
    for (int k = N-1; k >= 0; k--)
      if (req_rot[k]) off = SW'(k);
  end

  assign sum       = {1'b0, ptr} + {1'b0, off};
  assign grant_idx = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N)) : SW'(sum);
  assign grant_any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter with a registered output word and select index.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_sel_q, out_sel_d;

  logic [SW-1:0]       grant_idx;
  logic                grant_any;
  logic                can_accept, in_hs;
  logic [N-1:0][W-1:0] data_arr;

  rr_grant #(.N(N)) u_grant (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign data_arr   = in_data;
  assign can_accept = !out_valid_q || out_ready;
  assign in_hs      = rst_n && can_accept && grant_any;
  assign in_ready   = in_hs ? (N'(1) << grant_idx) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (in_hs) begin
      // Covers the back-to-back case: a drain and an accept in one cycle.
      ptr_d       = SW'(next_idx(IDX_W'(grant_idx), N));
      out_valid_d = 1'b1;
      out_data_d  = data_arr[grant_idx];
      out_sel_d   = grant_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
